// File: rtl/noc_output_port_pkg.sv
// noc_output_port_pkg: CHDR field offsets, FC type code and FSM state types.
package noc_output_port_pkg;

  localparam int CHDR_TYPE_HI = 63;
  localparam int CHDR_TYPE_LO = 62;
  localparam int CHDR_SEQ_HI  = 59;
  localparam int CHDR_SEQ_LO  = 48;
  localparam int CHDR_LEN_HI  = 47;
  localparam int CHDR_LEN_LO  = 32;
  localparam int CHDR_SID_HI  = 31;
  localparam int CHDR_SID_LO  = 0;

  localparam logic [1:0] CHDR_TYPE_FC = 2'b01;

  typedef enum logic {DATA_HDR, DATA_BODY} data_state_e;
  typedef enum logic [1:0] {FC_HDR, FC_PAYLOAD, FC_DROP} fc_state_e;

  function automatic logic [63:0] chdr_set_seq(input logic [63:0] w, input logic [11:0] s);
    logic [63:0] r;
    r = w;
    r[CHDR_SEQ_HI:CHDR_SEQ_LO] = s;
    return r;
  endfunction

endpackage

// File: rtl/noc_fc_ack_parser.sv
// noc_fc_ack_parser: consumes flow-control packets and latches the acked packet count.
module noc_fc_ack_parser
  import noc_output_port_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [63:0] fc_tdata,
  input  logic        fc_tlast,
  input  logic        fc_tvalid,
  output logic        fc_tready,
  output logic [31:0] ack_cnt,
  output logic        ack_stb
);

  fc_state_e   state_q, state_d;
  logic [31:0] ack_q, ack_d;
  logic        unused_bits;

  assign unused_bits = ^fc_tdata[CHDR_SEQ_HI+2:CHDR_LEN_LO];
  assign ack_cnt     = ack_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= FC_HDR;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end

  always_comb begin
    state_d = state_q;
    if (fc_tvalid)
      case (state_q)
        FC_HDR:  state_d = fc_tlast ? FC_HDR :
                           (fc_tdata[CHDR_TYPE_HI:CHDR_TYPE_LO] == CHDR_TYPE_FC) ? FC_PAYLOAD : FC_DROP;
        default: state_d = fc_tlast ? FC_HDR : FC_DROP;
      endcase
    if (clear) state_d = FC_HDR;
  end

  // The sink is never backpressured, so every valid word is consumed.
  always_comb begin
    fc_tready = 1'b1;
    ack_stb   = fc_tvalid && state_q == FC_PAYLOAD;
    ack_d     = clear ? '0 : ack_stb ? fc_tdata[CHDR_SID_HI:CHDR_SID_LO] : ack_q;
  end

endmodule

// File: rtl/noc_output_port.sv
// noc_output_port: window-based flow control on CHDR packets toward the crossbar,
// restamping header sequence numbers and gating new packets on outstanding credit.
module noc_output_port
  import noc_output_port_pkg::*;
#(
  parameter logic [7:0] SR_FLOW_CTRL_WINDOW_SIZE = 8'd0,
  parameter logic [7:0] SR_FLOW_CTRL_WINDOW_EN   = 8'd1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  input  logic [63:0] fc_tdata,
  input  logic        fc_tlast,
  input  logic        fc_tvalid,
  output logic        fc_tready,
  output logic        window_full
);

  data_state_e state_q, state_d;
  logic [31:0] sent_q, sent_d, window_q, window_d, ack_cnt, in_flight;
  logic [11:0] seq_q, seq_d;
  logic        en_q, en_d, credit_ok, pass, done, unused_ack_stb;

  noc_fc_ack_parser u_fc (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .fc_tdata  (fc_tdata),
    .fc_tlast  (fc_tlast),
    .fc_tvalid (fc_tvalid),
    .fc_tready (fc_tready),
    .ack_cnt   (ack_cnt),
    .ack_stb   (unused_ack_stb)
  );

  // Modulo-2^32 difference keeps credit correct across counter wrap.
  assign in_flight   = sent_q - ack_cnt;
  assign credit_ok   = !en_q || in_flight < window_q;
  assign window_full = en_q && in_flight >= window_q;
  assign done        = i_tvalid && i_tready && i_tlast;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= DATA_HDR;
      sent_q   <= '0;
      seq_q    <= '0;
      window_q <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sent_q   <= sent_d;
      seq_q    <= seq_d;
      window_q <= window_d;
      en_q     <= en_d;
    end

  always_comb begin
    state_d = clear ? DATA_HDR :
              (i_tvalid && i_tready) ? (i_tlast ? DATA_HDR : DATA_BODY) : state_q;
    sent_d   = clear ? '0 : sent_q + {31'd0, done};
    seq_d    = clear ? '0 : seq_q + {11'd0, done};
    window_d = (set_stb && set_addr == SR_FLOW_CTRL_WINDOW_SIZE) ? set_data : window_q;
    en_d     = (set_stb && set_addr == SR_FLOW_CTRL_WINDOW_EN) ? set_data[0] : en_q;
  end

  // Credit gates only headers; reset forces the handshake low immediately.
  always_comb begin
    pass     = reset && (state_q == DATA_BODY || credit_ok);
    o_tvalid = i_tvalid && pass;
    i_tready = o_tready && pass;
    o_tdata  = state_q == DATA_HDR ? chdr_set_seq(i_tdata, seq_q) : i_tdata;
    o_tlast  = i_tlast;
  end

endmodule

// File: tb/tb_noc_output_port.sv
// tb_noc_output_port: randomized and directed stimulus checked every cycle against
// a packet-level model of credit, sequence numbering and ack parsing.
module tb_noc_output_port;

  logic        clk = 0, reset = 0, clear = 0, set_stb = 0;
  logic [7:0]  set_addr = 0;
  logic [31:0] set_data = 0;
  logic [63:0] i_tdata = 0, o_tdata, fc_tdata = 0;
  logic        i_tlast = 0, i_tvalid = 0, i_tready;
  logic        o_tlast, o_tvalid, o_tready = 1;
  logic        fc_tlast = 0, fc_tvalid = 0, fc_tready, window_full;

  int vectors = 0, miscompares = 0, cyc = 0;
  bit bp_en = 0, data_done = 0;

  int          m_widx = 0, f_idx = 0;
  logic [31:0] m_sent = 0, m_ack = 0, m_win = 0;
  logic        m_en = 0;
  logic [11:0] m_seq = 0;
  logic [1:0]  f_type = 0;
  logic [11:0] seq_log[$];

  always #5 clk = ~clk;

  noc_output_port dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .fc_tdata(fc_tdata), .fc_tlast(fc_tlast), .fc_tvalid(fc_tvalid), .fc_tready(fc_tready),
    .window_full(window_full)
  );

  function automatic bit credit();
    return !m_en || (m_sent - m_ack) < m_win;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    o_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_widx <= 0; m_sent <= 0; m_ack <= 0; m_seq <= 0;
      m_win <= 0; m_en <= 0; f_idx <= 0; f_type <= 0;
    end else begin
      if (set_stb && set_addr == 8'd0) m_win <= set_data;
      if (set_stb && set_addr == 8'd1) m_en <= set_data[0];
      if (clear) begin
        m_widx <= 0; m_sent <= 0; m_ack <= 0; m_seq <= 0; f_idx <= 0;
      end else begin
        if (i_tvalid && o_tready && (m_widx != 0 || credit())) begin
          if (i_tlast) begin
            m_widx <= 0; m_sent <= m_sent + 1; m_seq <= m_seq + 1;
          end else m_widx <= m_widx + 1;
        end
        if (fc_tvalid) begin
          f_idx <= fc_tlast ? 0 : f_idx + 1;
          if (f_idx == 0) f_type <= fc_tdata[63:62];
          if (f_idx == 1 && f_type == 2'b01) m_ack <= fc_tdata[31:0];
        end
      end
    end

  always @(negedge clk) begin
    logic        pass;
    logic [63:0] exp_data;
    pass = reset && (m_widx != 0 || credit());
    chk("o_tvalid", o_tvalid, i_tvalid && pass);
    chk("i_tready", i_tready, o_tready && pass);
    chk("window_full", window_full, reset && m_en && (m_sent - m_ack) >= m_win);
    chk("fc_tready", fc_tready, 1);
    if (i_tvalid && pass) begin
      exp_data = i_tdata;
      if (m_widx == 0) exp_data[59:48] = m_seq;
      chk("o_tdata", o_tdata, exp_data);
      chk("o_tlast", o_tlast, i_tlast);
      if (m_widx == 0 && o_tready) seq_log.push_back(o_tdata[59:48]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    set_stb = 1; set_addr = a; set_data = d;
    step();
    set_stb = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    step();
    clear = 0;
  endtask

  task automatic send_pkt(int len, bit gaps, int first);
    int budget;
    for (int w = first; w < len; w++) begin
      budget = 0;
      i_tdata = {$urandom(), $urandom()};
      if (w == 0) i_tdata[63:62] = 2'b00;
      i_tlast = (w == len - 1);
      forever begin
        i_tvalid = !gaps || $urandom_range(0, 3) != 0;
        @(negedge clk);
        if (i_tvalid && i_tready) begin
          step();
          break;
        end
        step();
        budget++;
        if (budget > 500) begin
          miscompares++;
          $display("FAIL send_timeout: word %0d never accepted", w);
          i_tvalid = 0;
          return;
        end
      end
    end
    i_tvalid = 0;
  endtask

  task automatic send_fc(logic [1:0] t, int len, logic [31:0] val);
    for (int w = 0; w < len; w++) begin
      fc_tdata = {$urandom(), $urandom()};
      if (w == 0) fc_tdata[63:62] = t;
      if (w == 1) fc_tdata[31:0] = val;
      fc_tlast = (w == len - 1);
      fc_tvalid = 1;
      step();
    end
    fc_tvalid = 0;
    fc_tlast = 0;
  endtask

  task automatic hold_hdr(logic last);
    i_tdata = {$urandom(), $urandom()};
    i_tdata[63:62] = 2'b00;
    i_tlast = last;
    i_tvalid = 1;
  endtask

  initial begin
    int c0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_o_tvalid", o_tvalid, 0);
    chk("rst_i_tready", i_tready, 0);
    chk("rst_window_full", window_full, 0);
    chk("rst_fc_tready", fc_tready, 1);
    step();
    reset = 1;
    step();

    // window disabled: three 4-word packets, no stall, seq 0..2
    seq_log.delete();
    c0 = cyc;
    repeat (3) send_pkt(4, 0, 0);
    chk("unstalled_cycles", cyc - c0, 12);
    chk("seq0", seq_log[0], 0);
    chk("seq1", seq_log[1], 1);
    chk("seq2", seq_log[2], 2);

    // window=2, no acks: third header held until ack of 1
    do_clear();
    wr(8'd0, 2); wr(8'd1, 1);
    send_pkt(4, 0, 0);
    send_pkt(4, 0, 0);
    hold_hdr(0);
    repeat (3) begin
      @(negedge clk);
      chk("held_hdr_tready", i_tready, 0);
      chk("held_window_full", window_full, 1);
      step();
    end
    send_fc(2'b01, 2, 1);
    @(negedge clk);
    chk("ack_release", i_tready, 1);
    step();
    send_pkt(4, 0, 1);

    // ack lands in the same cycle as tlast of packet 2
    do_clear();
    send_pkt(2, 0, 0);
    fork
      send_pkt(2, 0, 0);
      send_fc(2'b01, 2, 1);
    join
    chk("model_sent", m_sent, 2);
    chk("model_ack", m_ack, 1);
    hold_hdr(1);
    @(negedge clk);
    chk("coincident_hdr_pass", i_tready, 1);
    chk("coincident_window_full", window_full, 0);
    step();
    i_tvalid = 0;

    // ack near 2^32 with sent near 0: modulo credit
    do_clear();
    wr(8'd0, 4);
    send_fc(2'b01, 2, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("wrap_not_full", window_full, 0);
    step();
    send_pkt(1, 0, 0);
    send_pkt(1, 0, 0);
    hold_hdr(1);
    @(negedge clk);
    chk("wrap_full", window_full, 1);
    chk("wrap_blocked", i_tready, 0);
    step();
    i_tvalid = 0;

    // seq wraps 4095 -> 0
    do_clear();
    wr(8'd1, 0);
    seq_log.delete();
    repeat (4097) send_pkt(1, 0, 0);
    chk("seq_count", seq_log.size(), 4097);
    chk("seq_4095", seq_log[4095], 4095);
    chk("seq_wrap", seq_log[4096], 0);

    // non-FC packet on the fc port must not load ack
    do_clear();
    wr(8'd0, 1); wr(8'd1, 1);
    send_fc(2'b10, 5, 32'd5);
    hold_hdr(1);
    @(negedge clk);
    chk("non_fc_ignored", i_tready, 1);
    step();
    i_tvalid = 0;
    @(negedge clk);
    chk("non_fc_window_full", window_full, 1);
    step();

    // clear mid-BODY
    wr(8'd1, 0);
    send_pkt(2, 0, 0);
    send_pkt(2, 0, 0);
    hold_hdr(0);
    step();
    i_tdata = {$urandom(), $urandom()};
    step();
    clear = 1;
    step();
    clear = 0;
    i_tvalid = 0;
    seq_log.delete();
    send_pkt(2, 0, 0);
    chk("seq_after_clear", seq_log[0], 0);

    // reset mid-packet drops o_tvalid immediately
    hold_hdr(0);
    step();
    #2;
    reset = 0;
    #1;
    chk("rst_mid_o_tvalid", o_tvalid, 0);
    chk("rst_mid_i_tready", i_tready, 0);
    step();
    i_tvalid = 0;
    reset = 1;
    step();

    // randomized traffic with backpressure and concurrent acks
    bp_en = 1;
    wr(8'd0, 3); wr(8'd1, 1);
    fork
      begin
        for (int p = 0; p < 150; p++) begin
          if ($urandom_range(0, 9) == 0) begin
            wr(8'd0, $urandom_range(1, 4));
            wr(8'd1, $urandom_range(0, 1));
          end
          send_pkt($urandom_range(1, 5), 1, 0);
        end
        data_done = 1;
      end
      begin
        while (!data_done) begin
          if ($urandom_range(0, 1) != 0)
            send_fc(2'($urandom_range(0, 3)), $urandom_range(1, 4), m_sent - $urandom_range(0, 1));
          else
            step();
        end
      end
    join
    bp_en = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
